// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the sram_responder block.
//   resp_state_t : LOAD (program image streaming in) / SERVE (CPU accesses)
//   lane_mask_t  : per-byte-lane enable, bit1 = upper byte [15:8], bit0 = lower byte [7:0]
package sram_resp_pkg;

  typedef enum logic {LOAD, SERVE} resp_state_t;

  typedef logic [1:0] lane_mask_t;

  localparam logic [7:0] BYTE_ZERO   = 8'h00;
  localparam int unsigned SRAM_ADDR_W = 20;

endpackage

// File: rtl/sram_responder_if.sv
// SRAM-side bus of the SLC-3 memory controller plus the program-image load stream.
//   master : memory controller / loader (drives strobes, ADDR, Data_write, init stream)
//   slave  : sram_responder (drives Data_read, Data_oe, init_ready, busy, addr_err)
// Optional: SRAM_RESP_ACCESS_CNT_EN adds rd_count / wr_count driven by the slave.
interface sram_responder_if;

  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [19:0] ADDR;
  logic [15:0] Data_write;
  logic [15:0] Data_read;
  logic        Data_oe;
  logic        init_valid;
  logic [15:0] init_data;
  logic        init_ready;
  logic        busy;
  logic        addr_err;
`ifdef SRAM_RESP_ACCESS_CNT_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  modport master (
    output CE, UB, LB, OE, WE, ADDR, Data_write, init_valid, init_data,
    input  Data_read, Data_oe, init_ready, busy, addr_err
`ifdef SRAM_RESP_ACCESS_CNT_EN
    , input rd_count, wr_count
`endif
  );

  modport slave (
    input  CE, UB, LB, OE, WE, ADDR, Data_write, init_valid, init_data,
    output Data_read, Data_oe, init_ready, busy, addr_err
`ifdef SRAM_RESP_ACCESS_CNT_EN
    , output rd_count, wr_count
`endif
  );

endinterface

// File: rtl/sram_resp_array.sv
// Single-port synchronous RAM, 2**ADDR_W x 16, per-lane write enable, registered read.
//   clk   : clock
//   addr  : word address
//   we    : lane write enables (bit1 = [15:8], bit0 = [7:0])
//   wdata : write data
//   re    : read enable; rdata holds its last value when low
//   rdata : registered read data
// Contents are not reset.
module sram_resp_array
  import sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  lane_mask_t        we,
  input  logic [15:0]       wdata,
  input  logic              re,
  output logic [15:0]       rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [15:0] mem [Depth];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (re)    rdata_q         <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// On-chip stand-in for the 1Mx16 asynchronous SRAM behind the SLC-3 controller.
// After Reset a LOAD phase fills mem[0..INIT_WORDS-1] from the init stream, then the
// block serves CPU reads/writes (1-cycle read latency) until the next Reset.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : sram_responder_if.slave (strobes, ADDR, data buses, load stream, status)
// Optional: define SRAM_RESP_ACCESS_CNT_EN for saturating rd_count / wr_count outputs.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned INIT_WORDS = 256
) (
  input logic            Clk,
  input logic            Reset,
  sram_responder_if.slave bus
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(INIT_WORDS - 1);

  resp_state_t       state_q, state_d;
  logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
  logic              oe_q;
  logic [15:0]       rd_mask_q;
  logic              addr_err_q;

  logic              in_serve, oor, cpu_sel, cpu_wr, cpu_rd, oor_rd, load_fire;
  lane_mask_t        lanes, arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [15:0]       arr_wdata, arr_rdata, lane_bits;

  always_comb begin
    in_serve  = (state_q == SERVE);
    oor       = (bus.ADDR[SRAM_ADDR_W-1:ADDR_W] != '0);
    lanes     = {~bus.UB, ~bus.LB};
    lane_bits = {(lanes[1] ? 8'hFF : BYTE_ZERO), (lanes[0] ? 8'hFF : BYTE_ZERO)};
    cpu_sel   = in_serve && !bus.CE && !oor;
    // Write wins over OE when both strobes are low.
    cpu_wr    = cpu_sel && !bus.WE;
    cpu_rd    = cpu_sel && bus.WE && !bus.OE;
    oor_rd    = in_serve && !bus.CE && oor && bus.WE && !bus.OE;
    load_fire = !in_serve && bus.init_valid;
  end

  // The single RAM port belongs to the loader in LOAD and to the CPU in SERVE.
  always_comb begin
    arr_addr  = in_serve ? bus.ADDR[ADDR_W-1:0] : load_cnt_q;
    arr_wdata = in_serve ? bus.Data_write : bus.init_data;
    arr_we    = '0;
    if (in_serve) begin
      if (cpu_wr) arr_we = lanes;
    end else if (load_fire) begin
      arr_we = 2'b11;
    end
  end

  sram_resp_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (Clk),
    .addr  (arr_addr),
    .we    (arr_we),
    .wdata (arr_wdata),
    .re    (cpu_rd),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    unique case (state_q)
      LOAD: begin
        if (bus.init_valid) begin
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == LastIdx) state_d = SERVE;
        end
      end
      SERVE: ;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      oe_q       <= 1'b0;
      rd_mask_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      oe_q       <= cpu_rd || oor_rd;
      // A zero mask blanks the RAM register for idle cycles, out-of-range reads and
      // disabled lanes, so the RAM itself needs no reset.
      rd_mask_q  <= cpu_rd ? lane_bits : '0;
      if (in_serve && !bus.CE && oor) addr_err_q <= 1'b1;
    end
  end

  assign bus.Data_read  = arr_rdata & rd_mask_q;
  assign bus.Data_oe    = oe_q;
  assign bus.init_ready = !in_serve;
  assign bus.busy       = !in_serve;
  assign bus.addr_err   = addr_err_q;

`ifdef SRAM_RESP_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (cpu_rd && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (cpu_wr && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign bus.rd_count = rd_cnt_q;
  assign bus.wr_count = wr_cnt_q;
`endif

endmodule
